// File: rtl/ps2_rx_event_fifo.sv
// ps2_rx_event_fifo
//
// PS/2 keyboard receiver. It synchronises the raw PS/2 pins, frames 11-bit
// words (start, 8 data bits LSB first, odd parity, stop) and checks them.
// E0/F0 prefix bytes become ext/break flags on the scan code that follows.
// Each complete key event is queued in a show-ahead FIFO with a valid/ready
// interface.
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a PS2_CLK fall with data low (start bit)
// RECV   | shifting in bits 1..10; a gap of TIMEOUT_CYC cycles aborts
// CHECK  | one cycle: validate the frame, fold prefixes or push an event
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   PS2_CLK     in   raw PS/2 clock pin
//   PS2_DAT     in   raw PS/2 data pin
//   evt_ready   in   consumer accepts the head event
//   evt_valid   out  FIFO non-empty
//   evt_code    out  head scan code (0 when empty)
//   evt_ext     out  head event had an E0 prefix (0 when empty)
//   evt_break   out  head event had an F0 prefix (0 when empty)
//   frame_err   out  one-cycle pulse on a bad frame or receive timeout
//   overflow    out  one-cycle pulse when an event is dropped on a full FIFO
//   fifo_count  out  number of queued events

module ps2_rx_event_fifo #(
    parameter int CLK_HZ      = 50000000,
    parameter int TIMEOUT_US  = 2000,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DAT,
    input  logic                          evt_ready,
    output logic                          evt_valid,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TIMEOUT_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
    localparam int TCNT_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    // The abort fires in the cycle the counter would step onto TIMEOUT_CYC,
    // i.e. TIMEOUT_CYC cycles after the cycle in which the last fall was seen.
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers; reset to 1 (bus idle) so release sees no edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    assign fall  = clk_prev & ~clk_s;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t              state, state_nxt;
    logic [3:0]          bitcnt, bitcnt_nxt;
    logic [10:0]         shreg, shreg_nxt;
    logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
    logic                ext_pend, ext_nxt;
    logic                brk_pend, brk_nxt;
    logic                push_req;
    logic [7:0]          rx_data;
    logic                frame_ok;

    // Bits arrive LSB first into the MSB end, so after 11 shifts
    // shreg[0] is start, [8:1] data, [9] parity, [10] stop.
    assign rx_data  = shreg[8:1];
    assign frame_ok = ~shreg[0] & shreg[10] & (^shreg[9:1]);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            tcnt     <= '0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            bitcnt   <= bitcnt_nxt;
            shreg    <= shreg_nxt;
            tcnt     <= tcnt_nxt;
            ext_pend <= ext_nxt;
            brk_pend <= brk_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        tcnt_nxt   = tcnt;
        ext_nxt    = ext_pend;
        brk_nxt    = brk_pend;
        push_req   = 1'b0;
        frame_err  = 1'b0;

        case (state)
            IDLE: begin
                tcnt_nxt = '0;
                if (fall && !dat_s) begin
                    shreg_nxt  = {dat_s, shreg[10:1]};
                    bitcnt_nxt = 4'd1;
                    state_nxt  = RECV;
                end
            end

            RECV: begin
                if (fall) begin
                    shreg_nxt  = {dat_s, shreg[10:1]};
                    bitcnt_nxt = bitcnt + 4'd1;
                    tcnt_nxt   = '0;
                    if (bitcnt == 4'd10) begin
                        state_nxt = CHECK;
                    end
                end else if (tcnt == TCNT_LAST) begin
                    frame_err  = 1'b1;
                    ext_nxt    = 1'b0;
                    brk_nxt    = 1'b0;
                    bitcnt_nxt = '0;
                    tcnt_nxt   = '0;
                    state_nxt  = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TCNT_W'(1);
                end
            end

            CHECK: begin
                state_nxt  = IDLE;
                bitcnt_nxt = '0;
                if (!frame_ok) begin
                    frame_err = 1'b1;
                    ext_nxt   = 1'b0;
                    brk_nxt   = 1'b0;
                end else if (rx_data == 8'hE0) begin
                    ext_nxt = 1'b1;
                end else if (rx_data == 8'hF0) begin
                    brk_nxt = 1'b1;
                end else begin
                    push_req = 1'b1;
                    ext_nxt  = 1'b0;
                    brk_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Event FIFO: entry = {ext, break, code}
    // ------------------------------------------------------------------
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             pop;
    logic             do_push;
    logic [9:0]       head;

    assign full      = (count == CNT_FULL);
    assign evt_valid = (count != '0);
    assign pop       = evt_valid & evt_ready;
    // A pop in the same cycle frees the slot, so a push on a full FIFO
    // still lands when the consumer is draining.
    assign do_push   = push_req & (~full | pop);
    assign overflow  = push_req & full & ~pop;

    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem[wr_ptr] <= {ext_pend, brk_pend, rx_data};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign evt_code   = evt_valid ? head[7:0] : 8'h00;
    assign evt_break  = evt_valid ? head[8]   : 1'b0;
    assign evt_ext    = evt_valid ? head[9]   : 1'b0;
    assign fifo_count = count;

endmodule

// File: tb/tb_ps2_rx_event_fifo.sv
module tb_ps2_rx_event_fifo;

    localparam int CLK_HZ      = 1000000;
    localparam int TIMEOUT_US  = 100;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int H           = 8;   // PS/2 half period in system clocks

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       evt_ready;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       frame_err;
    logic       overflow;
    logic [2:0] fifo_count;

    ps2_rx_event_fifo #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .frame_err (frame_err),
        .overflow  (overflow),
        .fifo_count(fifo_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_fall = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int ovf_cnt = 0;
    int ovf_cyc = 0;
    int rise_cyc = 0;
    logic valid_q = 1'b0;
    int snap;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (frame_err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (overflow) begin
            ovf_cnt = ovf_cnt + 1;
            ovf_cyc = cyc;
        end
        if (evt_valid && !valid_q) rise_cyc = cyc;
        valid_q = evt_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives nbits of a frame. Odd parity is computed here; bad_par flips it.
    // pop_at_chk pulses evt_ready during the CHECK cycle of the final bit.
    task automatic send_frame(input logic [7:0] data, input bit bad_par,
                              input int nbits, input bit pop_at_chk);
        logic [10:0] fr;
        fr = {1'b1, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLOCK_50);
            PS2_DAT = fr[i];
            repeat (H) @(negedge CLOCK_50);
            PS2_CLK = 1'b0;
            last_fall = cyc;
            if (pop_at_chk && i == nbits - 1) begin
                repeat (SYNC_STAGES + 1) @(negedge CLOCK_50);
                evt_ready = 1'b1;
                @(negedge CLOCK_50);
                evt_ready = 1'b0;
                repeat (H - SYNC_STAGES - 2) @(negedge CLOCK_50);
            end else begin
                repeat (H) @(negedge CLOCK_50);
            end
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic pop_one;
        @(negedge CLOCK_50);
        evt_ready = 1'b1;
        @(negedge CLOCK_50);
        evt_ready = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        PS2_CLK   = 1'b1;
        PS2_DAT   = 1'b1;
        evt_ready = 1'b0;
        repeat (5) @(negedge CLOCK_50);

        // Reset state
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_code", 32'(evt_code), 32'h00);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        // Single 1C, latency: fall seen at last_fall+2, valid at +4
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        chk("lat_1c", 32'(rise_cyc - last_fall), 32'(SYNC_STAGES + 2));
        chk("code_1c", 32'(evt_code), 32'h1C);
        chk("ext_1c", 32'(evt_ext), 32'd0);
        chk("brk_1c", 32'(evt_break), 32'd0);
        chk("cnt_1c", 32'(fifo_count), 32'd1);
        pop_one();
        chk("cnt_pop", 32'(fifo_count), 32'd0);
        chk("code_empty", 32'(evt_code), 32'h00);
        pop_one();
        chk("cnt_pop_empty", 32'(fifo_count), 32'd0);

        // F0 1C -> break event, then lone 1C make event
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        chk("cnt_f0_only", 32'(fifo_count), 32'd0);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        chk("cnt_f0_1c", 32'(fifo_count), 32'd1);
        chk("code_f0_1c", 32'(evt_code), 32'h1C);
        chk("brk_f0_1c", 32'(evt_break), 32'd1);
        chk("ext_f0_1c", 32'(evt_ext), 32'd0);
        pop_one();
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        chk("brk_lone_1c", 32'(evt_break), 32'd0);
        chk("code_lone_1c", 32'(evt_code), 32'h1C);
        pop_one();

        // E0 F0 75 -> single extended break event
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        send_frame(8'h75, 1'b0, 11, 1'b0);
        chk("cnt_e0f075", 32'(fifo_count), 32'd1);
        chk("code_e0f075", 32'(evt_code), 32'h75);
        chk("ext_e0f075", 32'(evt_ext), 32'd1);
        chk("brk_e0f075", 32'(evt_break), 32'd1);
        pop_one();

        // Parity error clears pending E0
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        snap = err_cnt;
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        chk("par_err_pulses", 32'(err_cnt - snap), 32'd1);
        chk("par_err_cycle", 32'(err_cyc - last_fall), 32'(SYNC_STAGES + 1));
        chk("par_err_cnt", 32'(fifo_count), 32'd0);
        send_frame(8'h75, 1'b0, 11, 1'b0);
        chk("code_after_err", 32'(evt_code), 32'h75);
        chk("ext_after_err", 32'(evt_ext), 32'd0);
        pop_one();

        // Timeout after 5 bits: 100 cycles after the detected fall
        snap = err_cnt;
        send_frame(8'h1C, 1'b0, 5, 1'b0);
        repeat (130) @(negedge CLOCK_50);
        chk("to_pulses", 32'(err_cnt - snap), 32'd1);
        chk("to_cycle", 32'(err_cyc - last_fall), 32'(SYNC_STAGES + 100));
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        chk("to_recover_cnt", 32'(fifo_count), 32'd1);
        chk("to_recover_code", 32'(evt_code), 32'h1C);
        pop_one();

        // Fill, overflow, push-with-pop while full, drain
        snap = ovf_cnt;
        send_frame(8'h15, 1'b0, 11, 1'b0);
        send_frame(8'h16, 1'b0, 11, 1'b0);
        send_frame(8'h1E, 1'b0, 11, 1'b0);
        send_frame(8'h26, 1'b0, 11, 1'b0);
        chk("full_cnt", 32'(fifo_count), 32'd4);
        chk("full_no_ovf", 32'(ovf_cnt - snap), 32'd0);
        send_frame(8'h25, 1'b0, 11, 1'b0);
        chk("ovf_pulses", 32'(ovf_cnt - snap), 32'd1);
        chk("ovf_cycle", 32'(ovf_cyc - last_fall), 32'(SYNC_STAGES + 1));
        chk("ovf_cnt", 32'(fifo_count), 32'd4);
        chk("ovf_head", 32'(evt_code), 32'h15);
        snap = ovf_cnt;
        send_frame(8'h2E, 1'b0, 11, 1'b1);
        chk("pushpop_no_ovf", 32'(ovf_cnt - snap), 32'd0);
        chk("pushpop_cnt", 32'(fifo_count), 32'd4);
        chk("drain0", 32'(evt_code), 32'h16);
        pop_one();
        chk("drain1", 32'(evt_code), 32'h1E);
        pop_one();
        chk("drain2", 32'(evt_code), 32'h26);
        pop_one();
        chk("drain3", 32'(evt_code), 32'h2E);
        pop_one();
        chk("drain_cnt", 32'(fifo_count), 32'd0);
        chk("drain_valid", 32'(evt_valid), 32'd0);

        // Reset mid-frame with an event queued
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        send_frame(8'h16, 1'b0, 4, 1'b0);
        chk("pre_rst_valid", 32'(evt_valid), 32'd1);
        snap = err_cnt;
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(evt_valid), 32'd0);
        chk("mid_rst_code", 32'(evt_code), 32'h00);
        chk("mid_rst_cnt", 32'(fifo_count), 32'd0);
        chk("mid_rst_err", 32'(frame_err), 32'd0);
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (200) @(negedge CLOCK_50);
        chk("post_rst_no_err", 32'(err_cnt - snap), 32'd0);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        chk("post_rst_cnt", 32'(fifo_count), 32'd1);
        chk("post_rst_code", 32'(evt_code), 32'h1C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
